// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN nibble-serial weight-load protocol.
// The transmitter and the receiver both use these so that bus bit positions match.
package bnn_pkg;

  // Default frame length (weight words per frame).
  localparam int DEF_NUM_NEURONS = 8;

  // Bit positions on the 8-bit serial bus.
  localparam int NIBBLE_MSB  = 7;
  localparam int NIBBLE_LSB  = 4;
  localparam int LOAD_EN_BIT = 3;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_SEND_LO = 3'd2,
    ST_SEND_HI = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5
  } bnn_tx_state_e;

  // Build one load cycle: nibble on the upper bits, load_en set, low bits zero.
  function automatic logic [7:0] ser_word(input logic [3:0] nibble);
    logic [7:0] word_v;
    word_v = '0;
    word_v[NIBBLE_MSB:NIBBLE_LSB] = nibble;
    word_v[LOAD_EN_BIT] = 1'b1;
    return word_v;
  endfunction

endpackage

// File: rtl/bnn_weight_tx.sv
// Host-side transmitter for the BNN nibble-serial weight-load protocol.
// Each accepted 8-bit word goes out as two adjacent load cycles, low nibble
// first. A pair is never split: abort only takes effect on pair boundaries.
module bnn_weight_tx
  import bnn_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int GAP_CYCLES  = 1,
  // A single-word frame still needs a one-bit index port.
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             word_valid,
  input  logic [7:0]       word_data,
  output logic             word_ready,
  output logic [7:0]       ser_out,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] neuron_idx
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

  bnn_tx_state_e    state_reg;
  logic [7:0]       word_reg;
  logic [7:0]       ser_out_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             abort_pend_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [GAP_W-1:0] gap_cnt_reg;

  // Ready comes straight from the state register so upstream never sees a
  // combinational path from its own valid.
  assign word_ready = (state_reg == ST_FETCH);
  assign ser_out    = ser_out_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign neuron_idx = idx_reg;

  // FSM with registered outputs: each output is set for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      word_reg       <= '0;
      ser_out_reg    <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      abort_pend_reg <= 1'b0;
      idx_reg        <= '0;
      gap_cnt_reg    <= '0;
    end else begin
      // Bus idles low and done is a single-cycle pulse unless set below.
      ser_out_reg <= '0;
      done_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // abort in the same cycle as start keeps us idle
          if (start && !abort) begin
            state_reg <= ST_FETCH;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ST_FETCH: begin
          // abort takes priority over a word offered in the same cycle
          if (abort) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
          end else if (word_valid) begin
            word_reg       <= word_data;
            ser_out_reg    <= ser_word(word_data[3:0]);
            abort_pend_reg <= 1'b0;
            state_reg      <= ST_SEND_LO;
          end
        end
        ST_SEND_LO: begin
          // The high nibble always follows; an abort here is only remembered.
          ser_out_reg    <= ser_word(word_reg[7:4]);
          abort_pend_reg <= abort;
          state_reg      <= ST_SEND_HI;
        end
        ST_SEND_HI: begin
          if (abort || abort_pend_reg) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            busy_reg       <= 1'b0;
            abort_pend_reg <= 1'b0;
          end else if (idx_reg == IDX_LAST) begin
            state_reg <= ST_DONE;
            idx_reg   <= '0;
            done_reg  <= 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state_reg   <= ST_GAP;
            gap_cnt_reg <= '0;
          end else begin
            state_reg <= ST_FETCH;
            idx_reg   <= idx_reg + IDX_W'(1);
          end
        end
        ST_GAP: begin
          if (abort) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
          end else if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= ST_FETCH;
            idx_reg   <= idx_reg + IDX_W'(1);
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_weight_tx.sv
// Directed bench for bnn_weight_tx: frame timing, nibble order, stall,
// abort, restart/reset robustness and a zero-gap build, with a receiver model.
module tb_bnn_weight_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, word_valid;
  logic [7:0] word_data;
  logic       word_ready;
  logic [7:0] ser_out;
  logic       busy, done;
  logic [2:0] neuron_idx;

  logic       start0, abort0, word_valid0;
  logic [7:0] word_data0;
  logic       word_ready0;
  logic [7:0] ser_out0;
  logic       busy0, done0;
  logic [2:0] neuron_idx0;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [7:0] w [8] = '{8'hF0, 8'h0F, 8'h3C, 8'hC3, 8'hF0, 8'h0F, 8'h3C, 8'hC3};
  logic [7:0] ab [8] = '{8'h12, 8'h34, 8'h56, 8'hA5, 8'h77, 8'h88, 8'h99, 8'hAA};
  logic [7:0] log_q [$];
  logic [2:0] idx_seen [8];

  int done_cnt, done_at, ready_stall, le_when_ready;

  always #5 clk = ~clk;

  bnn_weight_tx #(.NUM_NEURONS(8), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .ser_out(ser_out), .busy(busy), .done(done), .neuron_idx(neuron_idx)
  );

  bnn_weight_tx #(.NUM_NEURONS(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0),
    .word_valid(word_valid0), .word_data(word_data0), .word_ready(word_ready0),
    .ser_out(ser_out0), .busy(busy0), .done(done0), .neuron_idx(neuron_idx0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one frame on the GAP_CYCLES=1 instance, logging ser_out per cycle.
  task automatic run_frame(input int stall_word, input int stall_len, input int restart_at);
    int wi;
    int stall;
    log_q.delete();
    done_cnt = 0; done_at = -1; ready_stall = 0; le_when_ready = 0;
    wi = 0; stall = 0;
    start = 1'b1; word_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c < 200; c++) begin
      log_q.push_back(ser_out);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (word_ready && ser_out[3]) le_when_ready++;
      if (done_cnt > 0 && !busy) break;
      start = (c == restart_at);
      if (word_ready) begin
        if (wi == stall_word) ready_stall++;
        if (wi < 8) idx_seen[wi] = neuron_idx;
      end
      if (word_ready && wi == stall_word && stall < stall_len) begin
        word_valid = 1'b0;
        stall++;
      end else begin
        word_valid = (wi < 8);
        word_data  = (wi < 8) ? w[wi] : 8'h00;
      end
      if (word_ready && word_valid) wi++;
      tick();
    end
    start = 1'b0;
    word_valid = 1'b0;
  endtask

  // Receiver model: pair consecutive load cycles low-then-high into weights.
  task automatic check_loopback(input string tag);
    logic [7:0] rw [8];
    logic [3:0] lo;
    logic       phase;
    int ri, run, bad_pairs, bad_bits;
    phase = 1'b0; lo = '0; ri = 0; run = 0; bad_pairs = 0; bad_bits = 0;
    for (int k = 0; k < 8; k++) rw[k] = 8'h00;
    foreach (log_q[i]) begin
      if (log_q[i][2:0] != 3'b000 || (!log_q[i][3] && log_q[i] != 8'h00)) bad_bits++;
      if (log_q[i][3]) begin
        run++;
        if (!phase) begin
          lo = log_q[i][7:4];
          phase = 1'b1;
        end else begin
          if (ri < 8) rw[ri] = {log_q[i][7:4], lo};
          ri++;
          phase = 1'b0;
        end
      end else begin
        if (run != 0 && run != 2) bad_pairs++;
        run = 0;
      end
    end
    if (run != 0 && run != 2) bad_pairs++;
    chk({tag, "_words"}, ri, 8);
    chk({tag, "_pairs"}, bad_pairs, 0);
    chk({tag, "_bits"}, bad_bits, 0);
    for (int k = 0; k < 8; k++) chk($sformatf("%s_w%0d", tag, k), rw[k], w[k]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wi, dcnt, hit, le_n, bad_le;
    reset = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = 8'h00;
    start0 = 1'b0; abort0 = 1'b0; word_valid0 = 1'b0; word_data0 = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_ser", ser_out, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", neuron_idx, 0);
    chk("rst_ready", word_ready, 0);

    // Basic frame, words always valid.
    run_frame(99, 0, -1);
    chk("f1_w0_lo", log_q[1], 8'h08);
    chk("f1_w0_hi", log_q[2], 8'hF8);
    chk("f1_w0_gap", log_q[3], 8'h00);
    chk("f1_w1_lo", log_q[5], 8'hF8);
    chk("f1_w1_hi", log_q[6], 8'h08);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_done_at", done_at, 32);
    for (int k = 0; k < 8; k++) chk($sformatf("f1_idx%0d", k), idx_seen[k], k);
    chk("f1_idx_end", neuron_idx, 0);
    check_loopback("f1");

    // Stall 5 cycles before word 2.
    run_frame(2, 5, -1);
    chk("st_ready_len", ready_stall, 6);
    chk("st_le_ready", le_when_ready, 0);
    chk("st_done_cnt", done_cnt, 1);
    chk("st_done_at", done_at, 37);
    check_loopback("st");

    // Second start mid-frame must not disturb it.
    run_frame(99, 0, 10);
    chk("rs_done_cnt", done_cnt, 1);
    chk("rs_done_at", done_at, 32);
    check_loopback("rs");

    // Abort in SEND_LO of word 3 (0xA5).
    tick();
    start = 1'b1; tick(); start = 1'b0;
    wi = 0; dcnt = 0; hit = 0;
    for (int c = 0; c < 100 && hit == 0; c++) begin
      if (done) dcnt++;
      if (word_ready && wi < 8) begin
        word_valid = 1'b1; word_data = ab[wi];
        if (wi == 3) hit = 1;
        wi++;
      end else begin
        word_valid = 1'b0;
      end
      tick();
    end
    word_valid = 1'b0;
    chk("ab_lo", ser_out, 8'h58);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_hi", ser_out, 8'hA8);
    chk("ab_busy_hi", busy, 1);
    tick();
    chk("ab_ser_idle", ser_out, 8'h00);
    chk("ab_busy_fall", busy, 0);
    chk("ab_idx", neuron_idx, 0);
    for (int c = 0; c < 5; c++) begin
      if (done) dcnt++;
      tick();
    end
    chk("ab_no_done", dcnt, 0);

    // Abort while waiting in FETCH.
    start = 1'b1; tick(); start = 1'b0;
    chk("af_ready", word_ready, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("af_busy", busy, 0);
    chk("af_ready_off", word_ready, 0);

    // abort and start together in IDLE: stays idle.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("as_busy", busy, 0);
    chk("as_ready", word_ready, 0);

    // Reset during SEND_HI of word 1.
    start = 1'b1; tick(); start = 1'b0;
    wi = 0; le_n = 0;
    for (int c = 0; c < 100; c++) begin
      if (ser_out[3]) le_n++;
      if (le_n == 4) break;
      if (word_ready) begin word_valid = 1'b1; word_data = w[wi]; wi++; end
      tick();
    end
    chk("rh_in_hi", ser_out, 8'h08);
    reset = 1'b1; start = 1'b1; word_valid = 1'b1; tick();
    reset = 1'b0; start = 1'b0;
    chk("rh_ser", ser_out, 8'h00);
    chk("rh_busy", busy, 0);
    chk("rh_done", done, 0);
    chk("rh_idx", neuron_idx, 0);
    chk("rh_ready", word_ready, 0);
    tick();
    chk("rh_idle", word_ready, 0);
    word_valid = 1'b0;

    // Zero-gap build: back-to-back words.
    log_q.delete();
    start0 = 1'b1; tick(); start0 = 1'b0;
    wi = 0; done_at = -1; dcnt = 0; bad_le = 0;
    for (int c = 1; c < 200; c++) begin
      log_q.push_back(ser_out0);
      if (c <= 24 && ser_out0[3] != (c % 3 != 1)) bad_le++;
      if (done0) begin
        dcnt++;
        if (done_at < 0) done_at = c;
      end
      if (dcnt > 0 && !busy0) break;
      if (word_ready0 && wi < 8) begin
        word_valid0 = 1'b1; word_data0 = w[wi]; wi++;
      end
      tick();
    end
    word_valid0 = 1'b0;
    chk("g0_le_pattern", bad_le, 0);
    chk("g0_done_at", done_at, 25);
    chk("g0_done_cnt", dcnt, 1);
    check_loopback("g0");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
